// File: rtl/d7_pkg.sv
// Shared types and helpers for the modulo-N code stream checker.
package d7_pkg;

  localparam int unsigned CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Successor of a code in the modulo-`modulus` count sequence.
  function automatic logic [CODE_W-1:0] succ(input logic [CODE_W-1:0] code,
                                             input int unsigned       modulus);
    if (32'(code) == modulus - 32'd1) return '0;
    return code + CODE_W'(1);
  endfunction

endpackage

// File: rtl/d7_sat_cnt.sv
// Event counter with synchronous clear priority; SAT selects saturate (1) or wrap (0).
module d7_sat_cnt #(
  parameter int unsigned W   = 8,
  parameter bit          SAT = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic         at_max_c;

  assign at_max_c = SAT && (cnt_q == {W{1'b1}});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !at_max_c) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/d7_seq_checker.sv
// Tracks a modulo-MODULUS code stream, locks after a run of correct steps,
// then flags deviations and counts errors and completed wraps.
module d7_seq_checker
  import d7_pkg::*;
#(
  parameter int unsigned MODULUS    = 7,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned ERR_W      = 8,
  parameter int unsigned WRAP_W     = 8
) (
  input  logic              Cp,
  input  logic              R,
  input  logic              en,
  input  logic              y1,
  input  logic              y2,
  input  logic              y3,
  input  logic              clr,
  output logic              locked,
  output logic              err,
  output logic              wrap,
  output logic [CODE_W-1:0] expected,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam int unsigned GOOD_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int unsigned CW1    = CODE_W + 1;
  localparam logic [CW1-1:0]    MOD_V    = CW1'(MODULUS);
  localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(MODULUS - 1);
  localparam logic [GOOD_W-1:0] LOCK_V   = GOOD_W'(LOCK_COUNT);

  state_e              state_q;
  logic [CODE_W-1:0]   prev_q;
  logic [GOOD_W-1:0]   good_q;
  logic                locked_q;
  logic                err_q;
  logic                wrap_q;
  logic [CODE_W-1:0]   expected_q;

  logic [CODE_W-1:0]   code_c;
  logic [CODE_W-1:0]   succ_prev_c;
  logic [CODE_W-1:0]   succ_code_c;
  logic [GOOD_W-1:0]   good_inc_c;
  logic                legal_c;
  logic                match_c;
  logic                err_c;
  logic                wrap_c;

  assign code_c      = {y3, y2, y1};
  assign legal_c     = ({1'b0, code_c} < MOD_V);
  assign succ_prev_c = succ(prev_q, MODULUS);
  assign succ_code_c = succ(code_c, MODULUS);
  assign match_c     = legal_c && (code_c == succ_prev_c);
  assign good_inc_c  = good_q + GOOD_W'(1);

  // Event strobes feed both the pulse registers and the counters on the same edge.
  assign err_c  = en && (!legal_c || ((state_q == LOCKED) && !match_c));
  assign wrap_c = en && (state_q == LOCKED) && match_c && (prev_q == MAX_CODE);

  always_ff @(posedge Cp or posedge R) begin
    if (R) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      good_q     <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      wrap_q     <= 1'b0;
      expected_q <= '0;
    end else begin
      err_q  <= err_c;
      wrap_q <= wrap_c;
      if (en) begin
        if (!legal_c) begin
          state_q    <= IDLE;
          prev_q     <= '0;
          good_q     <= '0;
          locked_q   <= 1'b0;
          expected_q <= '0;
        end else begin
          prev_q     <= code_c;
          expected_q <= succ_code_c;
          unique case (state_q)
            IDLE: begin
              state_q <= TRAIN;
              good_q  <= '0;
            end
            TRAIN: begin
              if (match_c && (good_inc_c == LOCK_V)) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                good_q   <= '0;
              end else if (match_c) begin
                good_q <= good_inc_c;
              end else begin
                good_q <= '0;
              end
            end
            LOCKED: begin
              if (!match_c) begin
                state_q  <= TRAIN;
                locked_q <= 1'b0;
                good_q   <= '0;
              end
            end
            default: begin
              state_q  <= IDLE;
              locked_q <= 1'b0;
              good_q   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign wrap     = wrap_q;
  assign expected = expected_q;

  d7_sat_cnt #(.W(ERR_W), .SAT(1'b1)) u_err_cnt (
    .clk_i (Cp),
    .rst_i (R),
    .inc_i (err_c),
    .clr_i (clr),
    .cnt_o (err_cnt)
  );

  d7_sat_cnt #(.W(WRAP_W), .SAT(1'b0)) u_wrap_cnt (
    .clk_i (Cp),
    .rst_i (R),
    .inc_i (wrap_c),
    .clr_i (clr),
    .cnt_o (wrap_cnt)
  );

endmodule

// File: tb/tb_d7_seq_checker.sv
// Randomised and directed checks of d7_seq_checker against a run-length reference model.
module tb_d7_seq_checker;

  localparam int MOD = 7;
  localparam int LC  = 3;

  logic       Cp = 1'b0;
  logic       R = 1'b1;
  logic       en = 1'b0;
  logic       y1 = 1'b0, y2 = 1'b0, y3 = 1'b0;
  logic       clr = 1'b0;

  logic       locked, err, wrap;
  logic [2:0] expected;
  logic [7:0] err_cnt, wrap_cnt;
  logic       locked_s, err_s, wrap_s;
  logic [2:0] expected_s;
  logic [1:0] err_cnt_s;
  logic [7:0] wrap_cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a valid previous code plus an unbounded run of correct steps.
  bit m_active;
  int m_prev;
  int m_run;
  bit m_err, m_wrap;
  int m_errs, m_errs_s, m_wraps;

  always #5 Cp = ~Cp;

  d7_seq_checker dut (
    .Cp(Cp), .R(R), .en(en), .y1(y1), .y2(y2), .y3(y3), .clr(clr),
    .locked(locked), .err(err), .wrap(wrap), .expected(expected),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  d7_seq_checker #(.MODULUS(7), .LOCK_COUNT(3), .ERR_W(2), .WRAP_W(8)) dut_s (
    .Cp(Cp), .R(R), .en(en), .y1(y1), .y2(y2), .y3(y3), .clr(clr),
    .locked(locked_s), .err(err_s), .wrap(wrap_s), .expected(expected_s),
    .err_cnt(err_cnt_s), .wrap_cnt(wrap_cnt_s)
  );

  logic [37:0] dut_vec;
  assign dut_vec = {locked, err, wrap, expected, err_cnt, wrap_cnt,
                    locked_s, err_s, wrap_s, expected_s, err_cnt_s, wrap_cnt_s};

  function automatic bit m_locked();
    return m_active && (m_run >= LC);
  endfunction

  function automatic logic [2:0] m_exp();
    return m_active ? 3'((m_prev + 1) % MOD) : 3'd0;
  endfunction

  function automatic logic [37:0] model_vec();
    return {m_locked(), m_err, m_wrap, m_exp(), 8'(m_errs), 8'(m_wraps),
            m_locked(), m_err, m_wrap, m_exp(), 2'(m_errs_s), 8'(m_wraps)};
  endfunction

  function automatic void model_reset();
    m_active = 1'b0; m_prev = 0; m_run = 0;
    m_err = 1'b0; m_wrap = 1'b0;
    m_errs = 0; m_errs_s = 0; m_wraps = 0;
  endfunction

  function automatic void model_step(input bit e, input int c, input bit cl);
    bit was_locked;
    m_err  = 1'b0;
    m_wrap = 1'b0;
    if (e) begin
      if (c >= MOD) begin
        m_err = 1'b1; m_active = 1'b0; m_run = 0;
      end else if (!m_active) begin
        m_active = 1'b1; m_prev = c; m_run = 0;
      end else begin
        was_locked = (m_run >= LC);
        if (c == (m_prev + 1) % MOD) begin
          if (was_locked && m_prev == MOD - 1) m_wrap = 1'b1;
          m_run++;
        end else begin
          if (was_locked) m_err = 1'b1;
          m_run = 0;
        end
        m_prev = c;
      end
    end
    if (cl) begin
      m_errs = 0; m_errs_s = 0; m_wraps = 0;
    end else begin
      if (m_err && m_errs < 255) m_errs++;
      if (m_err && m_errs_s < 3) m_errs_s++;
      if (m_wrap) m_wraps = (m_wraps + 1) % 256;
    end
  endfunction

  task automatic step(input bit e, input int c, input bit cl);
    @(negedge Cp);
    en = e; {y3, y2, y1} = 3'(c); clr = cl;
    @(posedge Cp);
    model_step(e, c, cl);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Cp);
    R = 1'b1; en = 1'b0; clr = 1'b0;
    model_reset();
    @(negedge Cp);
    R = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    n_tests++;
    if (dut_vec !== 38'd0) begin
      n_fail++; $display("FAIL reset: got %h want 0", dut_vec);
    end
    @(negedge Cp);
    R = 1'b0;
  endtask

  task automatic test_lock();
    int seq[4] = '{0, 1, 2, 3};
    do_reset();
    foreach (seq[i]) begin
      step(1'b1, seq[i], 1'b0);
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL lock[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
    n_tests++;
    if ({locked, expected, err_cnt} !== {1'b1, 3'd4, 8'd0}) begin
      n_fail++; $display("FAIL lock_final: got %b/%0d/%0d want 1/4/0", locked, expected, err_cnt);
    end
  endtask

  task automatic test_wrap();
    int seq[4] = '{4, 5, 6, 0};
    foreach (seq[i]) begin
      step(1'b1, seq[i], 1'b0);
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL wrap[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
    n_tests++;
    if ({wrap, wrap_cnt, err} !== {1'b1, 8'd1, 1'b0}) begin
      n_fail++; $display("FAIL wrap_final: got %b/%0d/%b want 1/1/0", wrap, wrap_cnt, err);
    end
  endtask

  task automatic test_mismatch();
    int seq[6] = '{1, 2, 5, 6, 0, 1};
    foreach (seq[i]) begin
      step(1'b1, seq[i], 1'b0);
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL mismatch[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
      if (i == 2) begin
        n_tests++;
        if ({err, locked, err_cnt, expected} !== {1'b1, 1'b0, 8'd1, 3'd6}) begin
          n_fail++; $display("FAIL jump: got %b/%b/%0d/%0d want 1/0/1/6", err, locked, err_cnt, expected);
        end
      end
    end
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL relock: got %b want 1", locked);
    end
  endtask

  task automatic test_illegal();
    int seq[7] = '{3, 7, 0, 1, 2, 3, 7};
    do_reset();
    foreach (seq[i]) begin
      step(1'b1, seq[i], 1'b0);
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL illegal[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
    n_tests++;
    if ({err, locked, expected, err_cnt} !== {1'b1, 1'b0, 3'd0, 8'd2}) begin
      n_fail++; $display("FAIL illegal_final: got %b/%b/%0d/%0d want 1/0/0/2", err, locked, expected, err_cnt);
    end
  endtask

  task automatic test_en_gating();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i, 1'b0);
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL gate_q[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
      if (i < 3) begin
        step(1'b0, int'($urandom_range(0, 7)), 1'b0);
        n_tests++;
        if (dut_vec !== model_vec()) begin
          n_fail++; $display("FAIL gate_h[%0d]: got %h want %h", i, dut_vec, model_vec());
        end
      end
    end
    n_tests++;
    if ({locked, err} !== 2'b10) begin
      n_fail++; $display("FAIL gate_lock: got %b/%b want 1/0", locked, err);
    end
    step(1'b1, 7, 1'b1);
    n_tests++;
    if ({err, err_cnt} !== {1'b1, 8'd0}) begin
      n_fail++; $display("FAIL clr_vs_err: got %b/%0d want 1/0", err, err_cnt);
    end
  endtask

  task automatic test_back_to_back_sat();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 7, 1'b0);
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL b2b[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
    n_tests++;
    if ({err_cnt_s, err_cnt, err} !== {2'd3, 8'd5, 1'b1}) begin
      n_fail++; $display("FAIL sat: got %0d/%0d/%b want 3/5/1", err_cnt_s, err_cnt, err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, i, 1'b0);
    step(1'b1, 6, 1'b0);
    step(1'b1, 0, 1'b0);
    n_tests++;
    if (dut_vec !== model_vec() || locked !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got %h want %h", dut_vec, model_vec());
    end
    #2;
    R = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (dut_vec !== 38'd0) begin
      n_fail++; $display("FAIL reset_mid: got %h want 0", dut_vec);
    end
    @(negedge Cp);
    R = 1'b0;
    step(1'b1, 4, 1'b0);
    n_tests++;
    if (dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL post_reset: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_random();
    int c, r;
    bit e, cl;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r  = int'($urandom_range(0, 99));
      if (r < 80) c = m_active ? (m_prev + 1) % MOD : int'($urandom_range(0, MOD - 1));
      else        c = int'($urandom_range(0, 7));
      e  = ($urandom_range(0, 9) != 0);
      cl = ($urandom_range(0, 59) == 0);
      step(e, c, cl);
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_mismatch();
    test_illegal();
    test_en_gating();
    test_back_to_back_sat();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
